// File: rtl/inst_fetch_queue.sv
// Instruction fetch stage: sequential address generation, single-outstanding memory request,
// and a small prefetch FIFO of {pc, word} pairs with redirect flush.
module inst_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DepthCnt = CW'(DEPTH);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   mem_addr_q, mem_addr_d;
  logic          mem_req_q, mem_req_d;
  logic          discard_q, discard_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic [31:0] pc_mem   [DEPTH];
  logic [31:0] word_mem [DEPTH];

  logic complete;
  logic hold;
  logic push;
  logic pop;

  assign complete = mem_req_q & mem_ack;
  assign hold     = mem_req_q & ~mem_ack;
  // Data returned for a flushed request, or completing alongside a redirect, is dropped.
  assign push     = complete & ~discard_q & ~redirect;
  assign pop      = inst_valid & inst_ready & ~redirect;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (redirect) begin
      fetch_pc_d = redirect_pc;
    end else if (complete && !discard_q) begin
      fetch_pc_d = mem_addr_q + 32'd4;
    end
  end

  // Discard is only meaningful while a request stays pending; any completion clears it.
  always_comb begin
    discard_d = 1'b0;
    if (hold) begin
      discard_d = discard_q | redirect;
    end
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (redirect) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // Issue only while the post-edge occupancy leaves room for the new request's data.
  always_comb begin
    mem_req_d  = 1'b0;
    mem_addr_d = mem_addr_q;
    if (hold) begin
      mem_req_d = 1'b1;
    end else if (count_d < DepthCnt) begin
      mem_req_d  = 1'b1;
      mem_addr_d = fetch_pc_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q <= RESET_PC;
      mem_addr_q <= RESET_PC;
      mem_req_q  <= 1'b0;
      discard_q  <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      mem_addr_q <= mem_addr_d;
      mem_req_q  <= mem_req_d;
      discard_q  <= discard_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_q]   <= mem_addr_q;
      word_mem[wr_ptr_q] <= mem_rdata;
    end
  end

  assign mem_req    = mem_req_q;
  assign mem_addr   = mem_addr_q;
  assign inst_valid = (count_q != '0);
  // Head outputs read as zero when empty so reset values appear without a clock.
  assign inst       = inst_valid ? word_mem[rd_ptr_q] : 32'd0;
  assign inst_pc    = inst_valid ? pc_mem[rd_ptr_q] : 32'd0;

endmodule
